// File: rtl/maze_nav_pkg.sv
// rtl/maze_nav_pkg.sv - headings, navigator state encoding and default geometry for the maze agent
package maze_nav_pkg;

    localparam logic [3:0] DIR_DOWN  = 4'b1000;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_PROBE   = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_WAIT_VB = 3'd4,
        ST_UPDATE  = 3'd5,
        ST_DONE    = 3'd6,
        ST_LOST    = 3'd7
    } nav_state_t;

    localparam int DEF_STEP_H   = 8;
    localparam int DEF_STEP_V   = 4;
    localparam int DEF_CENTER_H = 15;
    localparam int DEF_CENTER_V = 8;
    localparam int DEF_MAX_MISS = 3;
    localparam int DEF_GOAL_TOL = 8;
    localparam int DEF_LAST_H   = 701;
    localparam int DEF_LAST_V   = 287;

    // Pose arithmetic runs 11-bit signed so a step past either edge is visible before clamping.
    function automatic logic [9:0] clamp_coord(input logic signed [10:0] v, input int last);
        if (v < 0) return 10'd0;
        if (int'(v) > last) return 10'(last);
        return 10'(v);
    endfunction

endpackage

// File: rtl/nav_dir_select.sv
// rtl/nav_dir_select.sv - node heading pick: open directions minus the way back, priority down>left>up>right
module nav_dir_select
    import maze_nav_pkg::*;
(
    input  logic [3:0] i_heading,
    input  logic [3:0] i_dirs,
    output logic [3:0] o_node_heading
);

    logic [3:0] w_reverse;
    logic [3:0] w_cand;

    assign w_reverse = {i_heading[1], i_heading[0], i_heading[3], i_heading[2]};
    assign w_cand    = i_dirs & ~w_reverse;

    // A dead end (no candidate) turns the agent around.
    always_comb begin
        o_node_heading = w_reverse;
        if (w_cand[3])      o_node_heading = DIR_DOWN;
        else if (w_cand[2]) o_node_heading = DIR_LEFT;
        else if (w_cand[1]) o_node_heading = DIR_UP;
        else if (w_cand[0]) o_node_heading = DIR_RIGHT;
    end

endmodule

// File: rtl/maze_nav_sequencer.sv
// rtl/maze_nav_sequencer.sv - per-frame probe/decide/update sequencer that walks the agent through the maze
module maze_nav_sequencer
    import maze_nav_pkg::*;
#(
    parameter int STEP_H   = DEF_STEP_H,
    parameter int STEP_V   = DEF_STEP_V,
    parameter int CENTER_H = DEF_CENTER_H,
    parameter int CENTER_V = DEF_CENTER_V,
    parameter int MAX_MISS = DEF_MAX_MISS,
    parameter int GOAL_TOL = DEF_GOAL_TOL,
    parameter int LAST_H   = DEF_LAST_H,
    parameter int LAST_V   = DEF_LAST_V
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_frame_valid,
    input  logic        maze_defined,
    input  logic [9:0]  start_x,
    input  logic [9:0]  start_y,
    input  logic [9:0]  end_x,
    input  logic [9:0]  end_y,
    output logic        probe_req,
    output logic [9:0]  probe_x,
    output logic [9:0]  probe_y,
    input  logic        probe_ack,
    input  logic [3:0]  probe_dirs,
    input  logic        probe_empty_corners,
    input  logic        probe_straight,
    input  logic        probe_center_ok,
    input  logic [4:0]  probe_offset,
    output logic [9:0]  pose_x,
    output logic [9:0]  pose_y,
    output logic [3:0]  heading,
    output logic [2:0]  nav_state,
    output logic        goal_reached,
    output logic        lost,
    output logic [15:0] step_count
);

    localparam logic signed [10:0] L_STEP_H   = 11'(STEP_H);
    localparam logic signed [10:0] L_STEP_V   = 11'(STEP_V);
    localparam logic signed [10:0] L_CENTER_H = 11'(CENTER_H);
    localparam logic signed [10:0] L_CENTER_V = 11'(CENTER_V);
    localparam logic signed [10:0] L_GOAL_TOL = 11'(GOAL_TOL);

    nav_state_t        r_state;
    logic              r_vfv_d;
    logic              r_probe_req;
    logic              r_goal;
    logic              r_lost;
    logic              r_correct;
    logic [9:0]        r_pose_x;
    logic [9:0]        r_pose_y;
    logic [9:0]        r_end_x;
    logic [9:0]        r_end_y;
    logic [3:0]        r_heading;
    logic [3:0]        r_step_dir;
    logic [3:0]        r_dirs;
    logic              r_empty;
    logic              r_straight;
    logic              r_center_ok;
    logic [4:0]        r_offset;
    logic [15:0]       r_step_count;
    logic [7:0]        r_miss;

    logic              w_frame_start;
    logic [3:0]        w_node_heading;
    logic [7:0]        w_miss_next;
    logic signed [10:0] w_off;
    logic signed [10:0] w_dx;
    logic signed [10:0] w_dy;
    logic signed [10:0] w_nx;
    logic signed [10:0] w_ny;
    logic signed [10:0] w_gdx;
    logic signed [10:0] w_gabs;
    logic [9:0]        w_new_x;
    logic [9:0]        w_new_y;
    logic              w_goal_hit;

    nav_dir_select u_dir_select (
        .i_heading      (r_heading),
        .i_dirs         (r_dirs),
        .o_node_heading (w_node_heading)
    );

    assign w_frame_start = video_frame_valid & ~r_vfv_d;
    assign w_miss_next   = r_miss + 8'd1;
    assign w_off         = $signed({6'b0, r_offset});

    // The step follows the heading the probe was taken on; a node turn only affects later frames.
    always_comb begin
        w_dx = '0;
        w_dy = '0;
        case (r_step_dir)
            DIR_DOWN: w_dy = L_STEP_V;
            DIR_UP:   w_dy = -L_STEP_V;
            DIR_LEFT: w_dx = -L_STEP_H;
            default:  w_dx = L_STEP_H;
        endcase
        if (r_correct) begin
            if (r_step_dir == DIR_DOWN || r_step_dir == DIR_UP) w_dx = w_off - L_CENTER_H;
            else                                                w_dy = w_off - L_CENTER_V;
        end
        w_nx       = $signed({1'b0, r_pose_x}) + w_dx;
        w_ny       = $signed({1'b0, r_pose_y}) + w_dy;
        w_new_x    = clamp_coord(w_nx, LAST_H);
        w_new_y    = clamp_coord(w_ny, LAST_V);
        w_gdx      = $signed({1'b0, w_new_x}) - $signed({1'b0, r_end_x});
        w_gabs     = (w_gdx < 0) ? -w_gdx : w_gdx;
        w_goal_hit = (w_new_y >= r_end_y) && (w_gabs <= L_GOAL_TOL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_vfv_d      <= 1'b0;
            r_probe_req  <= 1'b0;
            r_goal       <= 1'b0;
            r_lost       <= 1'b0;
            r_correct    <= 1'b0;
            r_pose_x     <= '0;
            r_pose_y     <= '0;
            r_end_x      <= '0;
            r_end_y      <= '0;
            r_heading    <= DIR_DOWN;
            r_step_dir   <= DIR_DOWN;
            r_dirs       <= '0;
            r_empty      <= 1'b0;
            r_straight   <= 1'b0;
            r_center_ok  <= 1'b0;
            r_offset     <= '0;
            r_step_count <= '0;
            r_miss       <= '0;
        end else begin
            r_vfv_d <= video_frame_valid;
            if (!maze_defined) begin
                r_state     <= ST_IDLE;
                r_probe_req <= 1'b0;
                r_goal      <= 1'b0;
                r_lost      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_pose_x     <= start_x;
                        r_pose_y     <= start_y;
                        r_end_x      <= end_x;
                        r_end_y      <= end_y;
                        r_heading    <= DIR_DOWN;
                        r_goal       <= 1'b0;
                        r_lost       <= 1'b0;
                        r_step_count <= '0;
                        r_miss       <= '0;
                        r_state      <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (w_frame_start) r_state <= ST_PROBE;
                    end
                    ST_PROBE: begin
                        r_probe_req <= 1'b1;
                        if (probe_ack) begin
                            r_dirs      <= probe_dirs;
                            r_empty     <= probe_empty_corners;
                            r_straight  <= probe_straight;
                            r_center_ok <= probe_center_ok;
                            r_offset    <= probe_offset;
                            r_miss      <= '0;
                            r_probe_req <= 1'b0;
                            r_state     <= ST_DECIDE;
                        end else if (!video_frame_valid) begin
                            r_probe_req <= 1'b0;
                            r_miss      <= w_miss_next;
                            if (w_miss_next >= 8'(MAX_MISS)) begin
                                r_lost  <= 1'b1;
                                r_state <= ST_LOST;
                            end else begin
                                r_state <= ST_ARM;
                            end
                        end
                    end
                    ST_DECIDE: begin
                        r_step_dir <= r_heading;
                        if (!r_center_ok) begin
                            r_lost  <= 1'b1;
                            r_state <= ST_LOST;
                        end else begin
                            if (r_empty && !r_straight) begin
                                r_heading <= w_node_heading;
                                r_correct <= 1'b0;
                            end else begin
                                r_correct <= r_empty;
                            end
                            r_state <= ST_WAIT_VB;
                        end
                    end
                    ST_WAIT_VB: begin
                        if (!video_frame_valid) r_state <= ST_UPDATE;
                    end
                    ST_UPDATE: begin
                        r_pose_x <= w_new_x;
                        r_pose_y <= w_new_y;
                        if (r_step_count != 16'hFFFF) r_step_count <= r_step_count + 16'd1;
                        if (w_goal_hit) begin
                            r_goal  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_ARM;
                        end
                    end
                    default: begin
                        r_probe_req <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign probe_req    = r_probe_req;
    assign probe_x      = r_pose_x;
    assign probe_y      = r_pose_y;
    assign pose_x       = r_pose_x;
    assign pose_y       = r_pose_y;
    assign heading      = r_heading;
    assign nav_state    = r_state;
    assign goal_reached = r_goal;
    assign lost         = r_lost;
    assign step_count   = r_step_count;

endmodule

// File: tb/tb_maze_nav_sequencer.sv
// tb/tb_maze_nav_sequencer.sv - scenario and randomized bench for maze_nav_sequencer against a frame-level model
module tb_maze_nav_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        video_frame_valid;
    logic        maze_defined;
    logic [9:0]  start_x, start_y, end_x, end_y;
    logic        probe_req;
    logic [9:0]  probe_x, probe_y;
    logic        probe_ack;
    logic [3:0]  probe_dirs;
    logic        probe_empty_corners, probe_straight, probe_center_ok;
    logic [4:0]  probe_offset;
    logic [9:0]  pose_x, pose_y;
    logic [3:0]  heading;
    logic [2:0]  nav_state;
    logic        goal_reached, lost;
    logic [15:0] step_count;

    int checks = 0;
    int errors = 0;

    int         m_x, m_y, m_ex, m_ey, m_miss, m_steps;
    logic [3:0] m_head;
    bit         m_goal, m_lost;

    always #5 clk = ~clk;

    maze_nav_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .video_frame_valid   (video_frame_valid),
        .maze_defined        (maze_defined),
        .start_x             (start_x),
        .start_y             (start_y),
        .end_x               (end_x),
        .end_y               (end_y),
        .probe_req           (probe_req),
        .probe_x             (probe_x),
        .probe_y             (probe_y),
        .probe_ack           (probe_ack),
        .probe_dirs          (probe_dirs),
        .probe_empty_corners (probe_empty_corners),
        .probe_straight      (probe_straight),
        .probe_center_ok     (probe_center_ok),
        .probe_offset        (probe_offset),
        .pose_x              (pose_x),
        .pose_y              (pose_y),
        .heading             (heading),
        .nav_state           (nav_state),
        .goal_reached        (goal_reached),
        .lost                (lost),
        .step_count          (step_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] m_rev(input logic [3:0] h);
        case (h)
            4'b1000: return 4'b0010;
            4'b0010: return 4'b1000;
            4'b0100: return 4'b0001;
            default: return 4'b0100;
        endcase
    endfunction

    function automatic logic [3:0] m_pick(input logic [3:0] c);
        for (int b = 3; b >= 0; b--) if (c[b]) return 4'(1 << b);
        return 4'b0000;
    endfunction

    function automatic logic [44:0] dut_snap();
        return {nav_state, pose_x, pose_y, heading, step_count, goal_reached, lost};
    endfunction

    function automatic logic [44:0] model_snap();
        logic [2:0] st;
        st = m_lost ? 3'd7 : (m_goal ? 3'd6 : 3'd1);
        return {st, 10'(m_x), 10'(m_y), m_head, 16'(m_steps), m_goal, m_lost};
    endfunction

    task automatic model_init(input int sx, input int sy, input int ex, input int ey);
        m_x = sx; m_y = sy; m_ex = ex; m_ey = ey;
        m_head = 4'b1000; m_miss = 0; m_steps = 0; m_goal = 0; m_lost = 0;
    endtask

    // One whole frame in navigation terms: miss, lose track, or take one step.
    task automatic model_frame(input int kind, input logic [3:0] dirs, input bit empty, input bit straight,
                               input bit center, input int off);
        int dx, dy;
        logic [3:0] step, cand;
        bit corr;
        if (m_goal || m_lost) return;
        if (kind == 2) begin
            m_miss++;
            if (m_miss >= 3) m_lost = 1;
            return;
        end
        m_miss = 0;
        if (!center) begin
            m_lost = 1;
            return;
        end
        step = m_head;
        corr = 0;
        if (empty && !straight) begin
            cand   = dirs & ~m_rev(m_head);
            m_head = (cand == 4'b0) ? m_rev(m_head) : m_pick(cand);
        end else begin
            corr = empty;
        end
        dx = 0; dy = 0;
        if (step == 4'b1000)      dy = 4;
        else if (step == 4'b0010) dy = -4;
        else if (step == 4'b0100) dx = -8;
        else                      dx = 8;
        if (corr) begin
            if (dy != 0) dx = off - 15;
            else         dy = off - 8;
        end
        m_x = m_x + dx; if (m_x < 0) m_x = 0; if (m_x > 701) m_x = 701;
        m_y = m_y + dy; if (m_y < 0) m_y = 0; if (m_y > 287) m_y = 287;
        if (m_steps < 65535) m_steps++;
        if (m_y >= m_ey && (m_x - m_ex) <= 8 && (m_ex - m_x) <= 8) m_goal = 1;
    endtask

    task automatic configure(input int sx, input int sy, input int ex, input int ey);
        video_frame_valid = 0;
        maze_defined = 0;
        tick();
        start_x = 10'(sx); start_y = 10'(sy); end_x = 10'(ex); end_y = 10'(ey);
        maze_defined = 1;
        tick();
        model_init(sx, sy, ex, ey);
    endtask

    // kind 0: ack mid-frame, 1: ack on the frame-end cycle, 2: no ack.
    task automatic run_frame(input int kind, input logic [3:0] dirs, input bit empty, input bit straight,
                             input bit center, input int off,
                             output logic req, output int px, output int py, output int st);
        video_frame_valid = 1;
        tick();
        tick();
        req = probe_req; px = probe_x; py = probe_y; st = nav_state;
        if (kind == 2) begin
            video_frame_valid = 0;
            tick();
            tick();
        end else begin
            probe_dirs = dirs; probe_empty_corners = empty; probe_straight = straight;
            probe_center_ok = center; probe_offset = 5'(off); probe_ack = 1;
            if (kind == 1) video_frame_valid = 0;
            tick();
            probe_ack = 0;
            tick();
            video_frame_valid = 0;
            tick();
            tick();
        end
        model_frame(kind, dirs, empty, straight, center, off);
    endtask

    task automatic test_reset();
        reset = 0;
        tick();
        tick();
        checks++;
        if (nav_state !== 3'd0 || pose_x !== 10'd0 || pose_y !== 10'd0 || heading !== 4'b1000) begin
            errors++;
            $display("FAIL reset_pose got st=%0d x=%0d y=%0d h=%b want 0 0 0 1000", nav_state, pose_x, pose_y, heading);
        end
        checks++;
        if (probe_req !== 1'b0 || goal_reached !== 1'b0 || lost !== 1'b0 || step_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_flags got req=%b goal=%b lost=%b n=%0d want 0 0 0 0", probe_req, goal_reached, lost, step_count);
        end
        reset = 1;
        tick();
    endtask

    task automatic test_corridor();
        logic req; int px, py, st;
        configure(350, 60, 352, 275);
        checks++;
        if (nav_state !== 3'd1 || heading !== 4'b1000 || pose_x !== 10'd350 || pose_y !== 10'd60) begin
            errors++;
            $display("FAIL config_arm got st=%0d h=%b x=%0d y=%0d want 1 1000 350 60", nav_state, heading, pose_x, pose_y);
        end
        run_frame(0, 4'b1010, 1, 1, 1, 17, req, px, py, st);
        checks++;
        if (req !== 1'b1 || px != 350 || py != 60 || st != 2) begin
            errors++;
            $display("FAIL config_probe got req=%b x=%0d y=%0d st=%0d want 1 350 60 2", req, px, py, st);
        end
        checks++;
        if (pose_x !== 10'd352 || pose_y !== 10'd64 || heading !== 4'b1000 || step_count !== 16'd1) begin
            errors++;
            $display("FAIL corridor_step got x=%0d y=%0d h=%b n=%0d want 352 64 1000 1", pose_x, pose_y, heading, step_count);
        end
        checks++;
        if (dut_snap() !== model_snap()) begin
            errors++;
            $display("FAIL corridor_model got %h want %h", dut_snap(), model_snap());
        end
    endtask

    task automatic test_node();
        logic req; int px, py, st;
        configure(352, 100, 352, 275);
        run_frame(0, 4'b0101, 1, 0, 1, 10, req, px, py, st);
        checks++;
        if (heading !== 4'b0100 || pose_x !== 10'd352 || pose_y !== 10'd104) begin
            errors++;
            $display("FAIL node_turn got h=%b x=%0d y=%0d want 0100 352 104", heading, pose_x, pose_y);
        end
        run_frame(0, 4'b0001, 1, 0, 1, 10, req, px, py, st);
        checks++;
        if (heading !== 4'b0001 || pose_x !== 10'd344 || pose_y !== 10'd104) begin
            errors++;
            $display("FAIL node_dead_end got h=%b x=%0d y=%0d want 0001 344 104", heading, pose_x, pose_y);
        end
        run_frame(0, 4'b1111, 0, 1, 1, 0, req, px, py, st);
        checks++;
        if (dut_snap() !== model_snap()) begin
            errors++;
            $display("FAIL near_node_model got %h want %h", dut_snap(), model_snap());
        end
    endtask

    task automatic test_miss();
        logic req; int px, py, st;
        configure(200, 100, 352, 275);
        for (int i = 0; i < 3; i++) begin
            run_frame(2, 4'b0, 0, 0, 0, 0, req, px, py, st);
            checks++;
            if (dut_snap() !== model_snap()) begin
                errors++;
                $display("FAIL miss_%0d got %h want %h", i, dut_snap(), model_snap());
            end
        end
        checks++;
        if (nav_state !== 3'd7 || lost !== 1'b1 || probe_req !== 1'b0 || pose_x !== 10'd200 || pose_y !== 10'd100) begin
            errors++;
            $display("FAIL miss_lost got st=%0d lost=%b req=%b x=%0d y=%0d want 7 1 0 200 100", nav_state, lost, probe_req, pose_x, pose_y);
        end
        configure(200, 100, 352, 275);
        run_frame(2, 4'b0, 0, 0, 0, 0, req, px, py, st);
        run_frame(2, 4'b0, 0, 0, 0, 0, req, px, py, st);
        run_frame(0, 4'b1010, 1, 1, 1, 15, req, px, py, st);
        run_frame(2, 4'b0, 0, 0, 0, 0, req, px, py, st);
        run_frame(2, 4'b0, 0, 0, 0, 0, req, px, py, st);
        checks++;
        if (nav_state !== 3'd1 || lost !== 1'b0 || pose_y !== 10'd104) begin
            errors++;
            $display("FAIL miss_clear got st=%0d lost=%b y=%0d want 1 0 104", nav_state, lost, pose_y);
        end
        run_frame(2, 4'b0, 0, 0, 0, 0, req, px, py, st);
        checks++;
        if (dut_snap() !== model_snap()) begin
            errors++;
            $display("FAIL miss_relost got %h want %h", dut_snap(), model_snap());
        end
    endtask

    task automatic test_goal();
        logic req; int px, py, st;
        configure(350, 268, 352, 275);
        run_frame(0, 4'b1010, 1, 1, 1, 15, req, px, py, st);
        checks++;
        if (nav_state !== 3'd1 || pose_y !== 10'd272 || goal_reached !== 1'b0) begin
            errors++;
            $display("FAIL goal_short got st=%0d y=%0d goal=%b want 1 272 0", nav_state, pose_y, goal_reached);
        end
        run_frame(0, 4'b1010, 1, 1, 1, 15, req, px, py, st);
        checks++;
        if (nav_state !== 3'd6 || pose_x !== 10'd350 || pose_y !== 10'd276 || goal_reached !== 1'b1) begin
            errors++;
            $display("FAIL goal_hit got st=%0d x=%0d y=%0d goal=%b want 6 350 276 1", nav_state, pose_x, pose_y, goal_reached);
        end
        run_frame(0, 4'b1010, 1, 1, 1, 15, req, px, py, st);
        checks++;
        if (req !== 1'b0 || st != 6 || dut_snap() !== model_snap()) begin
            errors++;
            $display("FAIL goal_hold got req=%b st=%0d snap=%h want 0 6 %h", req, st, dut_snap(), model_snap());
        end
        maze_defined = 0;
        tick();
        checks++;
        if (nav_state !== 3'd0 || goal_reached !== 1'b0) begin
            errors++;
            $display("FAIL goal_clear got st=%0d goal=%b want 0 0", nav_state, goal_reached);
        end
    endtask

    task automatic test_abort();
        configure(300, 150, 352, 275);
        video_frame_valid = 1;
        tick();
        tick();
        checks++;
        if (probe_req !== 1'b1 || nav_state !== 3'd2) begin
            errors++;
            $display("FAIL abort_probe got req=%b st=%0d want 1 2", probe_req, nav_state);
        end
        maze_defined = 0;
        tick();
        checks++;
        if (probe_req !== 1'b0 || nav_state !== 3'd0) begin
            errors++;
            $display("FAIL abort_idle got req=%b st=%0d want 0 0", probe_req, nav_state);
        end
        video_frame_valid = 0;
        tick();
    endtask

    task automatic test_reset_mid_update();
        configure(100, 100, 352, 275);
        video_frame_valid = 1;
        tick();
        tick();
        probe_dirs = 4'b1010; probe_empty_corners = 1; probe_straight = 1; probe_center_ok = 1;
        probe_offset = 5'd20; probe_ack = 1;
        tick();
        probe_ack = 0;
        tick();
        video_frame_valid = 0;
        tick();
        checks++;
        if (nav_state !== 3'd5) begin
            errors++;
            $display("FAIL rst_upd_pre got st=%0d want 5", nav_state);
        end
        reset = 0;
        tick();
        checks++;
        if (dut_snap() !== {3'd0, 10'd0, 10'd0, 4'b1000, 16'd0, 1'b0, 1'b0} || probe_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_upd got %h req=%b want %h req=0", dut_snap(), probe_req,
                     {3'd0, 10'd0, 10'd0, 4'b1000, 16'd0, 1'b0, 1'b0});
        end
        reset = 1;
        maze_defined = 0;
        tick();
    endtask

    task automatic test_ack_frame_end();
        logic req; int px, py, st;
        configure(400, 200, 352, 287);
        run_frame(2, 4'b0, 0, 0, 0, 0, req, px, py, st);
        run_frame(2, 4'b0, 0, 0, 0, 0, req, px, py, st);
        video_frame_valid = 1;
        tick();
        tick();
        probe_dirs = 4'b1010; probe_empty_corners = 1; probe_straight = 1; probe_center_ok = 1;
        probe_offset = 5'd20; probe_ack = 1;
        video_frame_valid = 0;
        tick();
        probe_ack = 0;
        checks++;
        if (nav_state !== 3'd3 || lost !== 1'b0) begin
            errors++;
            $display("FAIL ack_end_decide got st=%0d lost=%b want 3 0", nav_state, lost);
        end
        tick();
        tick();
        tick();
        model_frame(1, 4'b1010, 1, 1, 1, 20);
        run_frame(2, 4'b0, 0, 0, 0, 0, req, px, py, st);
        run_frame(2, 4'b0, 0, 0, 0, 0, req, px, py, st);
        checks++;
        if (dut_snap() !== model_snap() || pose_x !== 10'd405 || pose_y !== 10'd204) begin
            errors++;
            $display("FAIL ack_end_step got %h want %h (x405 y204)", dut_snap(), model_snap());
        end
    endtask

    task automatic test_random();
        logic req; int px, py, st, kind, exp_x, exp_y;
        logic exp_req;
        configure($urandom_range(0, 701), $urandom_range(0, 287), $urandom_range(0, 701), $urandom_range(0, 287));
        for (int i = 0; i < 250; i++) begin
            if (m_goal || m_lost) begin
                configure($urandom_range(0, 701), $urandom_range(0, 287), $urandom_range(0, 701), $urandom_range(0, 287));
            end
            exp_req = !(m_goal || m_lost);
            exp_x = m_x;
            exp_y = m_y;
            kind = $urandom_range(0, 5);
            kind = (kind <= 2) ? 0 : ((kind == 3) ? 1 : 2);
            run_frame(kind, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 15) != 0), $urandom_range(0, 30), req, px, py, st);
            checks++;
            if (req !== exp_req || px != exp_x || py != exp_y) begin
                errors++;
                $display("FAIL rand_probe_%0d got req=%b x=%0d y=%0d want %b %0d %0d", i, req, px, py, exp_req, exp_x, exp_y);
            end
            checks++;
            if (dut_snap() !== model_snap()) begin
                errors++;
                $display("FAIL rand_step_%0d got %h want %h", i, dut_snap(), model_snap());
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 0; video_frame_valid = 0; maze_defined = 0;
        start_x = 0; start_y = 0; end_x = 0; end_y = 0;
        probe_ack = 0; probe_dirs = 0; probe_empty_corners = 0; probe_straight = 0;
        probe_center_ok = 0; probe_offset = 0;
        test_reset();
        test_corridor();
        test_node();
        test_miss();
        test_goal();
        test_abort();
        test_reset_mid_update();
        test_ack_frame_end();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
